// File: rtl/msi_stimulus_sequencer.sv
// msi_stimulus_sequencer
// Loadable vector memory that issues MSI stimulus vectors (request type, hit/miss,
// per-cache and directory coherence states) under a Valid/Ready handshake.
// Ports:
//   Clock, Reset          rising-edge clock, synchronous active-high reset
//   LoadEn/LoadAddr/Data  vector memory write port (ignored while Busy)
//   NumVectors, LoopMode  pass length and wrap mode, sampled on accepted Start
//   Start, Stop           sequence control (Stop wins)
//   Ready                 consumer accepts the presented vector
//   Valid, VecIndex       presented vector and its memory index
//   WriteRead, HitMiss,
//   stateCache,
//   stateDiretorio        vector fields
//   Busy, Done, Error     status; Error is sticky for illegal state codes
module msi_stimulus_sequencer #(
    parameter  int unsigned NUM_CACHES = 2,
    parameter  int unsigned DEPTH      = 16,
    localparam int unsigned IW         = $clog2(DEPTH),
    localparam int unsigned NW         = $clog2(DEPTH + 1),
    localparam int unsigned VW         = 4 + 3 * NUM_CACHES + 3
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    LoadEn,
    input  logic [IW-1:0]           LoadAddr,
    input  logic [VW-1:0]           LoadData,
    input  logic [NW-1:0]           NumVectors,
    input  logic                    LoopMode,
    input  logic                    Start,
    input  logic                    Stop,
    input  logic                    Ready,
    output logic                    Valid,
    output logic [1:0]              WriteRead,
    output logic [1:0]              HitMiss,
    output logic [3*NUM_CACHES-1:0] stateCache,
    output logic [2:0]              stateDiretorio,
    output logic [IW-1:0]           VecIndex,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Error
);

    localparam int unsigned SW = 3 * NUM_CACHES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NW-1:0]   n_q, n_d;
    logic            loop_q, loop_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic            error_q, error_d;
    logic            valid_q, busy_q, done_q;

    logic [VW-1:0]   mem [DEPTH];
    logic            mem_we;
    logic [IW-1:0]   rd_idx;
    logic [VW-1:0]   rd_data;
    logic [NW-1:0]   n_clamp;
    logic            is_last;
    logic            start_ok;

    // True when any cache or directory field is outside {I,S,M}
    function automatic logic has_illegal(input logic [VW-1:0] v);
        logic       bad;
        logic [2:0] f;
        bad = 1'b0;
        for (int i = 0; i <= int'(NUM_CACHES); i++) begin
            f = v[3*i +: 3];
            if (f == 3'd0 || f > 3'd3) bad = 1'b1;
        end
        return bad;
    endfunction

    assign mem_we   = LoadEn & ~Reset & (state_q != RUN);
    assign start_ok = Start & ~Stop;
    assign n_clamp  = (NumVectors > NW'(DEPTH)) ? NW'(DEPTH) : NumVectors;
    assign is_last  = ((NW'(idx_q) + NW'(1)) == n_q);

    // Next vector to present is either entry 0 (start/wrap) or the successor
    assign rd_idx   = (state_q == RUN && !is_last) ? (idx_q + IW'(1)) : '0;

    // Same-cycle load forwards so a Start sees the word written alongside it
    assign rd_data  = (mem_we && LoadAddr == rd_idx) ? LoadData : mem[rd_idx];

    // Vector storage, deliberately untouched by Reset
    always_ff @(posedge Clock) begin
        if (mem_we) mem[LoadAddr] <= LoadData;
    end

    // State and output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            loop_q  <= 1'b0;
            vec_q   <= '0;
            error_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            loop_q  <= loop_d;
            vec_q   <= vec_d;
            error_q <= error_d;
            valid_q <= (state_d == RUN);
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        loop_d  = loop_q;
        vec_d   = vec_q;
        error_d = error_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (Stop) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (start_ok) begin
                    n_d     = n_clamp;
                    loop_d  = LoopMode;
                    error_d = 1'b0;
                    if (n_clamp == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        idx_d   = '0;
                        vec_d   = rd_data;
                        error_d = has_illegal(rd_data);
                    end
                end
            end
            RUN: begin
                if (Stop) begin
                    // Abort discards any handshake in this cycle
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (Ready) begin
                    if (is_last && !loop_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = rd_idx;
                        vec_d   = rd_data;
                        error_d = error_q | has_illegal(rd_data);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Valid          = valid_q;
    assign Busy           = busy_q;
    assign Done           = done_q;
    assign Error          = error_q;
    assign VecIndex       = idx_q;
    assign WriteRead      = vec_q[VW-1 -: 2];
    assign HitMiss        = vec_q[VW-3 -: 2];
    assign stateCache     = vec_q[3 +: SW];
    assign stateDiretorio = vec_q[2:0];

endmodule
